machine_batch_configurator: RTL and testbench

MACHINE_BATCH_CONFIGURATOR -- requirements
Module: machine_batch_configurator

---
 rtl/machine_cfg_pkg.sv | 36 +++
 rtl/lane_min_select.sv | 37 +++
 rtl/machine_batch_configurator.sv | 147 ++++++++++++++
 tb/tb_machine_batch_configurator.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/machine_cfg_pkg.sv
// Shared types and helpers for the machine batch configurator.
package machine_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    COLLECT,
    COMMIT,
    DONE
  } state_t;

  // Press-count width able to hold 0..n.
  function automatic int unsigned btn_w_f(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned lane_w_f(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Low n bits set; widths up to 32 supported.
  function automatic logic [31:0] low_mask(input int unsigned n);
    if (n >= 32) return '1;
    return (32'd1 << n) - 32'd1;
  endfunction

  // Add that clamps at the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, low_mask(w)}) return low_mask(w);
    return sum[31:0];
  endfunction

endpackage

// File: rtl/lane_min_select.sv
// Picks the kept lane with the fewest active-button presses; lowest lane wins ties.
module lane_min_select
  import machine_cfg_pkg::*;
#(
  parameter int unsigned MAX_NUM_BUTTONS = 13,
  parameter int unsigned LANES           = 2,
  parameter int unsigned BTN_W           = btn_w_f(MAX_NUM_BUTTONS),
  parameter int unsigned LANE_W          = lane_w_f(LANES)
) (
  input  logic [LANES*MAX_NUM_BUTTONS-1:0] tdata,
  input  logic [LANES-1:0]                 tkeep,
  input  logic [BTN_W-1:0]                 num_buttons,
  output logic                             any_kept,
  output logic [BTN_W-1:0]                 min_count,
  output logic [LANE_W-1:0]                min_lane
);

  logic [MAX_NUM_BUTTONS-1:0] mask;
  logic [BTN_W-1:0]           cnt;

  always_comb begin
    mask      = MAX_NUM_BUTTONS'(low_mask(32'(num_buttons)));
    any_kept  = 1'b0;
    min_count = '1;
    min_lane  = '0;
    cnt       = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      cnt = BTN_W'($countones(tdata[i*MAX_NUM_BUTTONS +: MAX_NUM_BUTTONS] & mask));
      if (tkeep[i] && (!any_kept || (cnt < min_count))) begin
        any_kept  = 1'b1;
        min_count = cnt;
        min_lane  = LANE_W'(i);
      end
    end
  end

endmodule

// File: rtl/machine_batch_configurator.sv
// Runs a batch of machines, keeping each machine's minimum-press candidate and the batch total.
// Optional candidates_seen statistics port under `CONFIGURE_MACHINE_STATS_EN.
module machine_batch_configurator
  import machine_cfg_pkg::*;
#(
  parameter int unsigned MAX_NUM_BUTTONS = 13,
  parameter int unsigned LANES           = 2,
  parameter int unsigned MAX_MACHINES_W  = 16,
  parameter int unsigned TOTAL_W         = 24,
  parameter int unsigned BTN_W           = btn_w_f(MAX_NUM_BUTTONS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [MAX_MACHINES_W-1:0]        num_machines,
  input  logic [BTN_W-1:0]                 num_buttons,
  output logic                             mach_start,
  input  logic                             sol_tvalid,
  output logic                             sol_tready,
  input  logic [LANES*MAX_NUM_BUTTONS-1:0] sol_tdata,
  input  logic [LANES-1:0]                 sol_tkeep,
  input  logic                             sol_tlast,
  output logic                             machine_valid,
  output logic [BTN_W-1:0]                 machine_min,
  output logic [MAX_NUM_BUTTONS-1:0]       machine_buttons,
  output logic [TOTAL_W-1:0]               total_presses,
  output logic                             unsolvable,
  output logic                             done,
  input  logic                             accepted
`ifdef CONFIGURE_MACHINE_STATS_EN
  ,
  output logic [31:0]                      candidates_seen
`endif
);

  localparam int unsigned LANE_W = lane_w_f(LANES);

  state_t                     state_q, state_d;
  logic [MAX_MACHINES_W-1:0]  idx_q, nmach_q;
  logic [BTN_W-1:0]           best_min_q, best_min_d;
  logic [MAX_NUM_BUTTONS-1:0] best_btn_q, best_btn_d;
  logic                       beat, any_kept;
  logic [BTN_W-1:0]           beat_min;
  logic [LANE_W-1:0]          beat_lane;
  logic [MAX_NUM_BUTTONS-1:0] mask, beat_btn;

  assign beat     = sol_tvalid && sol_tready;
  assign mask     = MAX_NUM_BUTTONS'(low_mask(32'(num_buttons)));
  assign beat_btn = sol_tdata[32'(beat_lane)*MAX_NUM_BUTTONS +: MAX_NUM_BUTTONS] & mask;

  lane_min_select #(
    .MAX_NUM_BUTTONS(MAX_NUM_BUTTONS),
    .LANES          (LANES),
    .BTN_W          (BTN_W),
    .LANE_W         (LANE_W)
  ) u_lane_min_select (
    .tdata      (sol_tdata),
    .tkeep      (sol_tkeep),
    .num_buttons(num_buttons),
    .any_kept   (any_kept),
    .min_count  (beat_min),
    .min_lane   (beat_lane)
  );

  // Next state and running per-machine best.
  always_comb begin
    state_d    = state_q;
    best_min_d = best_min_q;
    best_btn_d = best_btn_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_machines == '0) ? DONE : ISSUE;
      ISSUE: begin
        best_min_d = '1;
        best_btn_d = '0;
        state_d    = COLLECT;
      end
      COLLECT: begin
        if (beat) begin
          if (any_kept && (beat_min < best_min_q)) begin
            best_min_d = beat_min;
            best_btn_d = beat_btn;
          end
          if (sol_tlast) state_d = COMMIT;
        end
      end
      COMMIT:  state_d = ((idx_q + MAX_MACHINES_W'(1)) == nmach_q) ? DONE : ISSUE;
      DONE:    if (accepted) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      nmach_q         <= '0;
      best_min_q      <= '1;
      best_btn_q      <= '0;
      mach_start      <= 1'b0;
      sol_tready      <= 1'b0;
      machine_valid   <= 1'b0;
      machine_min     <= '1;
      machine_buttons <= '0;
      total_presses   <= '0;
      unsolvable      <= 1'b0;
      done            <= 1'b0;
    end else begin
      state_q       <= state_d;
      best_min_q    <= best_min_d;
      best_btn_q    <= best_btn_d;
      mach_start    <= (state_d == ISSUE);
      sol_tready    <= (state_d == COLLECT);
      machine_valid <= (state_d == COMMIT);
      done          <= (state_d == DONE);
      if (state_d == COMMIT) begin
        machine_min     <= best_min_d;
        machine_buttons <= best_btn_d;
      end
      if (state_q == IDLE && start) begin
        idx_q         <= '0;
        nmach_q       <= num_machines;
        total_presses <= '0;
        unsolvable    <= 1'b0;
      end
      // An all-ones minimum means no lane was ever kept for this machine.
      if (state_q == COMMIT) begin
        idx_q <= idx_q + MAX_MACHINES_W'(1);
        if (machine_min == '1) unsolvable <= 1'b1;
        else total_presses <= TOTAL_W'(sat_add(32'(total_presses), 32'(machine_min), TOTAL_W));
      end
    end
  end

`ifdef CONFIGURE_MACHINE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      candidates_seen <= '0;
    end else if (state_q == IDLE && start) begin
      candidates_seen <= '0;
    end else if (beat) begin
      candidates_seen <= sat_add(candidates_seen, 32'($countones(sol_tkeep)), 32);
    end
  end
`endif

endmodule

// File: tb/tb_machine_batch_configurator.sv
// Scoreboard bench: expected per-machine minima are queued as beats are scheduled, checked on machine_valid.
module tb_machine_batch_configurator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_machines = '0;
  logic [3:0]  num_buttons = '0;
  logic        mach_start;
  logic        sol_tvalid = 1'b0;
  logic        sol_tready;
  logic [25:0] sol_tdata = '0;
  logic [1:0]  sol_tkeep = '0;
  logic        sol_tlast = 1'b0;
  logic        machine_valid;
  logic [3:0]  machine_min;
  logic [12:0] machine_buttons;
  logic [23:0] total_presses;
  logic        unsolvable;
  logic        done;
  logic        accepted = 1'b0;
`ifdef CONFIGURE_MACHINE_STATS_EN
  logic [31:0] candidates_seen;
`endif

  typedef struct {
    logic [12:0] l0;
    logic [12:0] l1;
    logic [1:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [3:0]  mn;
    logic [12:0] btn;
  } exp_t;

  beat_t beats_q[$];
  exp_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    mstart_cnt = 0;
  int    m_nb = 0;
  int    m_min = 15;
  logic [12:0] m_btn = '0;
  int    exp_total = 0;
  bit    exp_unsolv = 1'b0;

  machine_batch_configurator dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_machines   (num_machines),
    .num_buttons    (num_buttons),
    .mach_start     (mach_start),
    .sol_tvalid     (sol_tvalid),
    .sol_tready     (sol_tready),
    .sol_tdata      (sol_tdata),
    .sol_tkeep      (sol_tkeep),
    .sol_tlast      (sol_tlast),
    .machine_valid  (machine_valid),
    .machine_min    (machine_min),
    .machine_buttons(machine_buttons),
    .total_presses  (total_presses),
    .unsolvable     (unsolvable),
    .done           (done),
    .accepted       (accepted)
`ifdef CONFIGURE_MACHINE_STATS_EN
    ,
    .candidates_seen(candidates_seen)
`endif
  );

  always #5 clk = ~clk;

  // Commit monitor: every machine_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mach_start) mstart_cnt++;
    if (rst_n && machine_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL commit_unexpected: got min=%0d buttons=%b, expected no commit", machine_min, machine_buttons);
      end else begin
        e = exp_q.pop_front();
        if (machine_min !== e.mn || machine_buttons !== e.btn) begin
          miscompares++;
          $display("FAIL commit_value: got min=%0d buttons=%b, expected min=%0d buttons=%b",
                   machine_min, machine_buttons, e.mn, e.btn);
        end
      end
    end
  end

  task automatic new_batch(input int nb);
    m_nb = nb; m_min = 15; m_btn = '0;
    exp_total = 0; exp_unsolv = 1'b0; mstart_cnt = 0;
  endtask

  // Schedules a beat and folds it into the reference minimum for the current machine.
  task automatic add_beat(input logic [12:0] l0, input logic [12:0] l1, input logic [1:0] keep,
                          input logic last);
    logic [12:0] mk, ln;
    beat_t b;
    int c;
    exp_t e;
    mk = '0;
    for (int k = 0; k < 13; k++) if (k < m_nb) mk[k] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ln = ((i == 0) ? l0 : l1) & mk;
      c  = $countones(ln);
      if (keep[i] && c < m_min) begin m_min = c; m_btn = ln; end
    end
    b.l0 = l0; b.l1 = l1; b.keep = keep; b.last = last;
    beats_q.push_back(b);
    if (last) begin
      e.mn = 4'(m_min); e.btn = m_btn;
      exp_q.push_back(e);
      if (m_min == 15) exp_unsolv = 1'b1;
      else exp_total += m_min;
      m_min = 15; m_btn = '0;
    end
  endtask

  task automatic do_start(input logic [3:0] nb, input logic [15:0] nm);
    @(posedge clk); #1;
    num_buttons = nb; num_machines = nm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic present(input beat_t b);
    sol_tdata = {b.l1, b.l0}; sol_tkeep = b.keep; sol_tlast = b.last; sol_tvalid = 1'b1;
  endtask

  task automatic wait_mach_start();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mach_start === 1'b1) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL mach_start_timeout: got no pulse in 20 cycles, expected one");
    end
  endtask

  task automatic handshake();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sol_tready === 1'b1) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL tready_timeout: got sol_tready=%b for 50 cycles, expected 1", sol_tready);
    end
    @(posedge clk); #1;
    sol_tvalid = 1'b0; sol_tlast = 1'b0;
  endtask

  // Feeds all scheduled beats, machine by machine, then checks commit/done latency.
  task automatic run_batch(input logic [3:0] nb, input logic [15:0] nm);
    beat_t b;
    do_start(nb, nm);
    if (nm == 0) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b1) begin
        miscompares++;
        $display("FAIL zero_machines_done: got done=%b, expected 1", done);
      end
      return;
    end
    for (int m = 0; m < int'(nm); m++) begin
      if (beats_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL beat_queue: got empty queue, expected beats for machine %0d", m);
        return;
      end
      b = beats_q.pop_front();
      present(b);
      wait_mach_start();
      handshake();
      while (!b.last && beats_q.size() > 0) begin
        b = beats_q.pop_front();
        if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        present(b);
        handshake();
      end
    end
    @(negedge clk);
    vectors++;
    if (machine_valid !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL commit_latency: got valid=%b done=%b, expected valid=1 done=0", machine_valid, done);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_latency: got done=%b, expected 1", done);
    end
  endtask

  task automatic finish_batch(input int nm);
    vectors++;
    if (total_presses !== 24'(exp_total)) begin
      miscompares++;
      $display("FAIL total_presses: got %0d, expected %0d", total_presses, exp_total);
    end
    vectors++;
    if (unsolvable !== exp_unsolv) begin
      miscompares++;
      $display("FAIL unsolvable: got %b, expected %b", unsolvable, exp_unsolv);
    end
    vectors++;
    if (mstart_cnt != nm || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL machine_count: got %0d mach_start pulses, %0d pending commits, expected %0d and 0",
               mstart_cnt, exp_q.size(), nm);
    end
    @(posedge clk); #1; accepted = 1'b1;
    @(posedge clk); #1; accepted = 1'b0;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_release: got done=%b, expected 0", done);
    end
  endtask

  task automatic check_reset_values(input string tag);
    vectors++;
    if (sol_tready !== 1'b0 || mach_start !== 1'b0 || machine_valid !== 1'b0 ||
        machine_min !== 4'hF || machine_buttons !== 13'd0 || total_presses !== 24'd0 ||
        unsolvable !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got tready=%b mstart=%b valid=%b min=%0d btn=%b total=%0d unsolv=%b done=%b, expected 0 0 0 15 0 0 0 0",
               tag, sol_tready, mach_start, machine_valid, machine_min, machine_buttons,
               total_presses, unsolvable, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #7;
    check_reset_values("reset_values");
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("idle_after_reset");
  endtask

  task automatic test_basic();
    new_batch(4);
    add_beat(13'b1010, 13'b0001, 2'b11, 1'b1);
    run_batch(4'd4, 16'd1);
    finish_batch(1);
  endtask

  task automatic test_tie();
    new_batch(4);
    add_beat(13'b0011, 13'b0101, 2'b11, 1'b0);
    add_beat(13'b1001, 13'b1111, 2'b01, 1'b1);
    run_batch(4'd4, 16'd1);
    finish_batch(1);
  endtask

  task automatic test_back_to_back();
    new_batch(4);
    add_beat(13'b0001, 13'b0110, 2'b10, 1'b0);
    add_beat(13'b0000, 13'b0000, 2'b00, 1'b1);
    add_beat(13'b0111, 13'b1111, 2'b11, 1'b1);
    add_beat(13'b1110, 13'b1011, 2'b11, 1'b0);
    add_beat(13'b1000, 13'b0000, 2'b01, 1'b1);
    run_batch(4'd4, 16'd3);
    finish_batch(3);
  endtask

  task automatic test_mask();
    new_batch(3);
    add_beat(13'b1111_0001, 13'h1F06, 2'b11, 1'b1);
    run_batch(4'd3, 16'd1);
    finish_batch(1);
  endtask

  task automatic test_unsolvable();
    new_batch(4);
    add_beat(13'b0001, 13'b0011, 2'b00, 1'b0);
    add_beat(13'b0111, 13'b0001, 2'b00, 1'b1);
    add_beat(13'b0101, 13'b1111, 2'b01, 1'b1);
    run_batch(4'd4, 16'd2);
    finish_batch(2);
    new_batch(4);
    run_batch(4'd4, 16'd0);
    finish_batch(0);
  endtask

  task automatic test_reset_mid();
    beat_t b;
    new_batch(4);
    add_beat(13'b0011, 13'b1111, 2'b01, 1'b1);
    do_start(4'd4, 16'd2);
    b = beats_q.pop_front();
    present(b);
    wait_mach_start();
    handshake();
    b.l0 = 13'b0001; b.l1 = 13'b0001; b.keep = 2'b11; b.last = 1'b1;
    present(b);
    wait_mach_start();
    @(negedge clk);
    vectors++;
    if (sol_tready !== 1'b1 || total_presses !== 24'd2) begin
      miscompares++;
      $display("FAIL pre_reset_state: got tready=%b total=%0d, expected 1 and 2", sol_tready, total_presses);
    end
    #1 rst_n = 1'b0;
    #1 check_reset_values("reset_mid_collect");
    @(negedge clk); sol_tvalid = 1'b0; sol_tlast = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    new_batch(4);
    add_beat(13'b1010, 13'b0001, 2'b11, 1'b1);
    run_batch(4'd4, 16'd1);
    finish_batch(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_back_to_back();
    test_mask();
    test_unsolvable();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
